// File: rtl/pulse_tx_pkg.sv
// rtl/pulse_tx_pkg.sv - shared types and constants for the pulse transmitter
package pulse_tx_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Phase counters count down to zero, so a phase of n cycles loads n-1.
  function automatic logic [CNT_W-1:0] phase_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// rtl/phase_cnt.sv - loadable down-counter with zero flag, shared by HIGH and LOW phases
module phase_cnt
  import pulse_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_tx.sv
// rtl/pulse_tx.sv - request strobes to a registered pulse train with minimum high/low widths
module pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              sig_out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  if (HIGH_CYC < 1 || HIGH_CYC > 255) begin : g_bad_high
    $error("pulse_tx: HIGH_CYC must be in 1..255");
  end
  if (LOW_CYC < 1 || LOW_CYC > 255) begin : g_bad_low
    $error("pulse_tx: LOW_CYC must be in 1..255");
  end
  if (PEND_W < 1) begin : g_bad_pend
    $error("pulse_tx: PEND_W must be at least 1");
  end

  localparam logic [CNT_W-1:0]  HIGH_LOAD = phase_load(HIGH_CYC);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = phase_load(LOW_CYC);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             pend_any;
  logic             pend_full;
  logic             deq;
  logic             inc;

  phase_cnt u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (state != IDLE),
    .zero     (cnt_zero)
  );

  assign pend_any  = (pend != '0);
  assign pend_full = (pend == PEND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE with pend>0 only happens after a request landed in the final LOW cycle.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = HIGH_LOAD;
    deq       = 1'b0;
    case (state)
      IDLE: begin
        if (req || pend_any) begin
          state_nxt = HIGH;
          cnt_load  = 1'b1;
          deq       = pend_any;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          state_nxt = LOW;
          cnt_load  = 1'b1;
          cnt_val   = LOW_LOAD;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          if (pend_any) begin
            state_nxt = HIGH;
            cnt_load  = 1'b1;
            deq       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A request that starts a pulse straight from an empty IDLE is never queued.
  assign inc = req && ((state != IDLE) || pend_any);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (inc && !deq) begin
        if (pend_full) begin
          ovf <= 1'b1;
        end else begin
          pend <= pend + PEND_ONE;
        end
      end else if (deq && !inc) begin
        pend <= pend - PEND_ONE;
      end
    end
  end

  assign sig_out = (state == HIGH);
  assign busy    = (state != IDLE);
  assign done    = (state == LOW) && cnt_zero;

endmodule

// File: tb/tb_pulse_tx.sv
// tb/tb_pulse_tx.sv - directed per-cycle vectors for pulse_tx plus a far-end loopback detector
`timescale 1ns/1ps
module tb_pulse_tx;

  localparam int HIGH_CYC = 4;
  localparam int LOW_CYC  = 3;
  localparam int PEND_W   = 2;

  logic              clk = 1'b0;
  logic              rclk = 1'b0;
  logic              rst;
  logic              req;
  logic              sig_out;
  logic              busy;
  logic              done;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always #3 rclk = ~rclk;

  pulse_tx #(
    .HIGH_CYC (HIGH_CYC),
    .LOW_CYC  (LOW_CYC),
    .PEND_W   (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sig_out (sig_out),
    .busy    (busy),
    .done    (done),
    .pend    (pend),
    .ovf     (ovf)
  );

  // Far-end 2-flop synchronizer and edge detector on an unrelated clock.
  logic [2:0] rsync = 3'b000;
  int rises = 0;
  int falls = 0;
  always @(posedge rclk) begin
    rsync <= {rsync[1:0], sig_out};
    if (rsync[1] && !rsync[2]) rises <= rises + 1;
    if (!rsync[1] && rsync[2]) falls <= falls + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int digit(input string s, input int c);
    if (c >= s.len()) return 0;
    return int'(s[c]) - 48;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Column c of each string is cycle c: inputs driven and outputs expected in that cycle.
  task automatic run(input string name, input string rs, input string r, input string s,
                     input string b, input string d, input string o, input string p,
                     input int pulses);
    int r0;
    int f0;
    r0 = rises;
    f0 = falls;
    for (int c = 0; c < r.len(); c++) begin
      rst = (digit(rs, c) == 1);
      req = (digit(r, c) == 1);
      check($sformatf("%s sig_out c%0d", name, c), int'(sig_out), digit(s, c));
      check($sformatf("%s busy c%0d", name, c), int'(busy), digit(b, c));
      check($sformatf("%s done c%0d", name, c), int'(done), digit(d, c));
      check($sformatf("%s ovf c%0d", name, c), int'(ovf), digit(o, c));
      check($sformatf("%s pend c%0d", name, c), int'(pend), digit(p, c));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("%s far-end rises", name), rises - r0, pulses);
    check($sformatf("%s far-end falls", name), falls - f0, pulses);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;

    do_reset();
    run("single", "",
        "1000000000",
        "0111100000",
        "0111111100",
        "0000000100",
        "0000000000",
        "0000000000", 1);

    do_reset();
    run("queued", "",
        "101100000000000000000000",
        "011110001111000111100000",
        "011111111111111111111100",
        "000000010000001000000100",
        "000000000000000000000000",
        "000122221111111000000000", 3);

    do_reset();
    run("overflow", "",
        "111111000000000000000000000000",
        "011110001111000111100011110000",
        "011111111111111111111111111110",
        "000000010000001000000100000010",
        "000001100000000000000000000000",
        "001233332222222111111100000000", 4);

    do_reset();
    run("req_at_deq", "",
        "1010000100000000000001000000000",
        "0111100011110001111000011110000",
        "0111111111111111111111011111110",
        "0000000100000010000001000000010",
        "0000000000000000000000000000000",
        "0001111111111110000000100000000", 4);

    do_reset();
    run("reset_mid", "00010000",
        "11110000",
        "01110000",
        "01110000",
        "00000000",
        "00000000",
        "00120000", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
